// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Instructions are one or two 16-bit words; bit 15 of the first word marks a long one.
package fetch_pkg;

  typedef enum logic [1:0] {
    VEC_LO = 2'd0,
    VEC_HI = 2'd1,
    FETCH  = 2'd2,
    EXT    = 2'd3
  } fetch_state_e;

  localparam int          MEM_W    = 16;
  localparam int          LONG_BIT = 15;
  localparam int          INSTR_W  = 32;
  localparam logic [15:0] NOP      = 16'h0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: loads the reset vector, then walks the PC and
// assembles 16/32-bit instructions from 16-bit words for the IF/ID boundary.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W         = 32,
  parameter int                 MEM_W          = fetch_pkg::MEM_W,
  parameter logic [ADDR_W-1:0]  RESET_VEC_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [MEM_W-1:0]    imem_rdata,
  input  logic                stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic                instr_valid,
  output logic [ADDR_W-1:0]   pc
);

  fetch_state_e        state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [MEM_W-1:0]    lo_q;
  logic [MEM_W-1:0]    hi_q;
  logic [ADDR_W-1:0]   start_q;
  logic [INSTR_W-1:0]  instr_q;
  logic [ADDR_W-1:0]   instr_pc_q;
  logic                instr_valid_q;
  logic                redirect;

  // A redirect only counts once the vector load has finished.
  assign redirect = flush && (state_q == FETCH || state_q == EXT);

  always_comb begin
    case (state_q)
      VEC_LO:  imem_addr = RESET_VEC_ADDR;
      VEC_HI:  imem_addr = RESET_VEC_ADDR + ADDR_W'(1);
      default: imem_addr = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= VEC_LO;
      pc_q          <= '0;
      lo_q          <= '0;
      hi_q          <= '0;
      start_q       <= '0;
      instr_q       <= INSTR_W'(NOP);
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else if (redirect) begin
      pc_q          <= redirect_pc;
      state_q       <= FETCH;
      instr_valid_q <= 1'b0;
    end else if (!stall) begin
      case (state_q)
        VEC_LO: begin
          lo_q    <= imem_rdata;
          state_q <= VEC_HI;
        end
        VEC_HI: begin
          pc_q    <= ADDR_W'({imem_rdata, lo_q});
          state_q <= FETCH;
        end
        FETCH: begin
          pc_q <= pc_q + ADDR_W'(1);
          if (imem_rdata[LONG_BIT]) begin
            hi_q          <= imem_rdata;
            start_q       <= pc_q;
            instr_valid_q <= 1'b0;
            state_q       <= EXT;
          end else begin
            instr_q       <= INSTR_W'(imem_rdata);
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
          end
        end
        EXT: begin
          instr_q       <= INSTR_W'({hi_q, imem_rdata});
          instr_pc_q    <= start_q;
          instr_valid_q <= 1'b1;
          pc_q          <= pc_q + ADDR_W'(1);
          state_q       <= FETCH;
        end
        default: state_q <= VEC_LO;
      endcase
    end
  end

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

endmodule
